// File: rtl/pipe_addsub_seg.sv
// Pipelined N-bit adder/subtractor. The carry chain is cut into STAGES
// segments of W bits. Segment k is added in stage k, and each stage has one
// register. Result bits below the segment move forward with the beat, and
// operand bits above it are delayed with it.
//
// Handshake: a beat moves on a rising edge when valid and ready are both 1 on
// that edge. in_ready is driven only by out_ready and the last stage's valid
// bit, and never by in_valid. When the pipe is stalled (adv=0), every stage
// holds and the outputs do not change.
module pipe_addsub_seg #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int W    = N / STAGES;
  localparam int LAST = STAGES - 1;

  if ((STAGES < 1) || (STAGES > N) || ((N % STAGES) != 0)) begin : g_bad_param
    $error("pipe_addsub_seg: N must be a multiple of STAGES and 1 <= STAGES <= N");
  end

  // Stage registers. r_s[k] holds the result bits completed so far.
  logic [N-1:0]      r_a [STAGES];
  logic [N-1:0]      r_b [STAGES];
  logic [N-1:0]      r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;
  logic              r_ovf;

  // Inputs and next-state values for each stage.
  logic [N-1:0]      w_a_src [STAGES];
  logic [N-1:0]      w_b_src [STAGES];
  logic [N-1:0]      w_s_src [STAGES];
  logic [N-1:0]      w_s_nxt [STAGES];
  logic [STAGES-1:0] w_c_src;
  logic [STAGES-1:0] w_c_nxt;
  logic [STAGES-1:0] w_v_src;

  logic              w_adv;
  logic [N-1:0]      w_b_eff;
  logic              w_c0;
  logic              w_ovf_nxt;
  logic              w_unused_ops;

  // A subtract becomes a + ~b + 1, so cin is ignored in that mode.
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;
  assign w_b_eff  = sub ? ~b : b;
  assign w_c0     = sub | cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    logic [W:0] w_seg;

    if (k == 0) begin : g_head
      assign w_a_src[k] = a;
      assign w_b_src[k] = w_b_eff;
      assign w_s_src[k] = '0;
      assign w_c_src[k] = w_c0;
      assign w_v_src[k] = in_valid & w_adv;
    end else begin : g_tail
      assign w_a_src[k] = r_a[k-1];
      assign w_b_src[k] = r_b[k-1];
      assign w_s_src[k] = r_s[k-1];
      assign w_c_src[k] = r_c[k-1];
      assign w_v_src[k] = r_v[k-1];
    end

    // Add segment k using the carry from the stage before it.
    assign w_seg = {1'b0, w_a_src[k][k*W +: W]}
                 + {1'b0, w_b_src[k][k*W +: W]}
                 + {{W{1'b0}}, w_c_src[k]};

    assign w_c_nxt[k] = w_seg[W];

    // Put this segment's result bits into the partial sum.
    always_comb begin
      w_s_nxt[k]           = w_s_src[k];
      w_s_nxt[k][k*W +: W] = w_seg[W-1:0];
    end
  end

  // Signed overflow: the two operand MSBs are equal and the sum MSB differs.
  assign w_ovf_nxt = (w_a_src[LAST][N-1] == w_b_src[LAST][N-1]) &
                     (w_s_nxt[LAST][N-1] != w_a_src[LAST][N-1]);

  // The last stage's copy of the operands drives no output.
  assign w_unused_ops = ^{r_a[LAST], r_b[LAST]};

  // Shift every stage together when adv=1. Reset clears all stages, which
  // drops any beats still in the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
      r_c   <= '0;
      r_v   <= '0;
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= w_a_src[k];
        r_b[k] <= w_b_src[k];
        r_s[k] <= w_s_nxt[k];
      end
      r_c   <= w_c_nxt;
      r_v   <= w_v_src;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign out_valid = r_v[LAST];
  assign sum       = r_s[LAST];
  assign cout      = r_c[LAST];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_addsub_seg.sv
// Bench for pipe_addsub_seg. It uses an N=8/STAGES=2 instance for most
// checks and an N=16/STAGES=4 instance for carry chains and mid-stream reset.
// Expected results are hand-computed and packed as {cout, ovf, sum}.
module tb_pipe_addsub_seg;

  localparam int N    = 8;
  localparam int ST   = 2;
  localparam int N16  = 16;
  localparam int ST16 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 8/2 ----------------
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  pipe_addsub_seg #(.N(N), .STAGES(ST)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // ---------------- DUT 16/4 ----------------
  logic           rst16 = 1'b1;
  logic           in_valid16 = 1'b0;
  logic           in_ready16;
  logic [N16-1:0] a16 = '0;
  logic [N16-1:0] b16 = '0;
  logic           cin16 = 1'b0;
  logic           sub16 = 1'b0;
  logic           out_valid16;
  logic           out_ready16 = 1'b1;
  logic [N16-1:0] sum16;
  logic           cout16;
  logic           ovf16;

  pipe_addsub_seg #(.N(N16), .STAGES(ST16)) u_dut16 (
    .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [N+1:0] exp_q[$];
  int           rx_q[$];
  int           n_got = 0;
  logic [N+1:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Outputs are sampled on the falling edge. The next rising edge completes
  // the handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_got++;
      rx_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {22'd0, cout, ovf, sum}, 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {22'd0, cout, ovf, sum}, {22'd0, mon_exp});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // The caller is at posedge+1. Present one beat and hold it until the DUT
  // accepts it.
  task automatic send(input logic [7:0] oa, input logic [7:0] ob,
                      input logic oc, input logic os, input logic [9:0] e);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1; a = oa; b = ob; cin = oc; sub = os;
    while (!acc && n < 20) begin
      #1;
      acc = in_ready;
      if (acc) exp_q.push_back(e);
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob,
                       input logic oc, input logic os, input logic [9:0] e);
    int acc_edge;
    rx_q.delete();
    send(oa, ob, oc, os, e);
    acc_edge = cyc;
    in_valid = 1'b0;
    wait_drain();
    check("latency", (rx_q.size() > 0) ? (rx_q[0] - acc_edge) : -1, ST - 1);
  endtask

  task automatic op16(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                      input logic os, input logic [15:0] es, input logic ec, input logic eo);
    int n;
    in_valid16 = 1'b1; a16 = oa; b16 = ob; cin16 = oc; sub16 = os;
    #1;
    check("in_ready16", in_ready16, 1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    n = 1;
    while (!out_valid16 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency16", n, ST16);
    check("sum16", sum16, es);
    check("cout16", cout16, ec);
    check("ovf16", ovf16, eo);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus tables ----------------
  logic [7:0] sa [6];
  logic [7:0] sb [6];
  logic       sc [6];
  logic       ss [6];
  logic [9:0] se [6];

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int got0;
    int cnt;

    sa = '{8'h01, 8'hFF, 8'h80, 8'h3C, 8'h00, 8'h64};
    sb = '{8'h02, 8'h01, 8'h80, 8'h0F, 8'h01, 8'h32};
    sc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ss = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    se = '{10'h003, 10'h200, 10'h300, 10'h04C, 10'h0FF, 10'h232};

    // Reset for two cycles.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rst16 = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);

    // Directed single operations.
    out_ready = 1'b1;
    do_op(8'hF0, 8'h1F, 1'b1, 1'b0, 10'h210);
    do_op(8'h05, 8'h07, 1'b0, 1'b1, 10'h0FE);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 10'h180);
    do_op(8'h10, 8'h01, 1'b1, 1'b1, 10'h20F);
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 10'h37F);

    // Six beats back to back.
    rx_q.delete();
    got0 = n_got;
    for (int i = 0; i < 6; i++) send(sa[i], sb[i], sc[i], ss[i], se[i]);
    wait_drain();
    check("stream_count", n_got - got0, 6);
    check("stream_back_to_back", (rx_q.size() == 6) ? (rx_q[5] - rx_q[0]) : -1, 5);

    // Backpressure: fill the pipe, stall for 4 cycles, then release.
    got0 = n_got;
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, 1'b0, 10'h046);
    send(8'h7F, 8'h7F, 1'b0, 1'b0, 10'h1FE);
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b0; sub = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_hold", {22'd0, cout, ovf, sum}, 32'h046);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(8'hFF, 8'hFF, 1'b0, 1'b1, 10'h200);
    wait_drain();
    idle(3);
    check("bp_count", n_got - got0, 3);

    // Reset with two beats in flight on the 8/2 instance.
    send(8'h11, 8'h22, 1'b0, 1'b0, 10'h033);
    send(8'h33, 8'h44, 1'b0, 1'b0, 10'h077);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 8'h00);
    exp_q.delete();
    got0 = n_got;
    idle(6);
    check("midrst_no_beats", n_got - got0, 0);

    // Checks on the 16/4 instance: carries that cross segment boundaries.
    op16(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Reset with two beats in flight on the 16/4 instance.
    in_valid16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; sub16 = 1'b0;
    @(posedge clk); #1;
    a16 = 16'h4321; b16 = 16'h0101;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    rst16 = 1'b1;
    @(posedge clk); #1;
    rst16 = 1'b0;
    check("midrst16_out_valid", out_valid16, 0);
    check("midrst16_in_ready", in_ready16, 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid16) cnt++;
      @(posedge clk); #1;
    end
    check("midrst16_no_beats", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
